// File: rtl/msk_demodulator_if.sv
// Sample-stream and decoded-output bundle between the MSK sample source,
// the demodulator and the receive framer.
interface msk_demodulator_if;
    logic       enable;
    logic       sample_valid;
    logic [7:0] data_in;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] data_out;
    logic       byte_valid;
    logic       sym_err;

    modport master (
        output enable, sample_valid, data_in,
        input  bit_out, bit_valid, data_out, byte_valid, sym_err
    );

    modport slave (
        input  enable, sample_valid, data_in,
        output bit_out, bit_valid, data_out, byte_valid, sym_err
    );
endinterface

// File: rtl/msk_demodulator.sv
// MSK demodulator: half-symbol sum sign comparison, LSB-first byte assembly.
// Optional low-confidence flag on sym_err when MSK_DEMOD_ERR_EN is defined.
module msk_demodulator #(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int ERR_THRESH      = 64
) (
    input  logic               g_clk_rx,
    input  logic               reset,
    msk_demodulator_if.slave   bus
);
    localparam int HALF  = SAMPLES_PER_BIT / 2;
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int ACC_W = 9 + $clog2(HALF);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SAMPLES_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_accept;
    logic                     w_first_end;
    logic                     w_sym_end;
    logic signed [8:0]        w_sample;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_bit;
    logic [7:0]               w_byte;

    logic [CNT_W-1:0]         r_cnt;
    logic [2:0]               r_bit_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_s1;
    logic [7:0]               r_shift;
    logic                     r_bit_out;
    logic                     r_bit_valid;
    logic [7:0]               r_data_out;
    logic                     r_byte_valid;

    assign w_accept = bus.enable & bus.sample_valid;
    assign w_sample = $signed({1'b0, bus.data_in}) - 9'sd128;
    assign w_sum    = r_acc + ACC_W'(w_sample);
    // Equal signs of the two half sums mean a half-cycle (bit 1); zero is non-negative.
    assign w_bit    = (r_s1[ACC_W-1] == w_sum[ACC_W-1]);
    assign w_byte   = r_shift | (8'(w_bit) << r_bit_cnt);

    always_ff @(posedge g_clk_rx) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // IDLE accepts the first sample of bit 0 directly so no sample is lost on enable.
    always_comb begin
        w_state_next = r_state;
        w_first_end  = 1'b0;
        w_sym_end    = 1'b0;
        if (!bus.enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, FIRST_HALF: begin
                    w_state_next = FIRST_HALF;
                    if (w_accept && r_cnt == HALF_LAST) begin
                        w_first_end  = 1'b1;
                        w_state_next = SECOND_HALF;
                    end
                end
                SECOND_HALF: begin
                    if (w_accept && r_cnt == SYM_LAST) begin
                        w_sym_end    = 1'b1;
                        w_state_next = FIRST_HALF;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge g_clk_rx) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= '0;
            r_s1         <= '0;
            r_shift      <= '0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_data_out   <= '0;
            r_byte_valid <= 1'b0;
        end else if (!bus.enable) begin
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= '0;
            r_shift      <= '0;
            r_bit_valid  <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_bit_valid  <= 1'b0;
            r_byte_valid <= 1'b0;
            if (w_first_end) begin
                r_s1  <= w_sum;
                r_acc <= '0;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_sym_end) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_bit_out   <= w_bit;
                r_bit_valid <= 1'b1;
                r_bit_cnt   <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_data_out   <= w_byte;
                    r_byte_valid <= 1'b1;
                    r_shift      <= '0;
                end else begin
                    r_shift <= w_byte;
                end
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.bit_out    = r_bit_out;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.data_out   = r_data_out;
    assign bus.byte_valid = r_byte_valid;

`ifdef MSK_DEMOD_ERR_EN
    logic [ACC_W-1:0] w_mag;
    logic             w_low;
    logic             r_err;
    logic             r_sym_err;

    // |sum| cannot overflow: the most negative half sum is only -2^(ACC_W-2).
    assign w_mag = w_sum[ACC_W-1] ? $unsigned(-w_sum) : $unsigned(w_sum);
    assign w_low = (w_mag < ACC_W'(ERR_THRESH));

    always_ff @(posedge g_clk_rx) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_sym_err <= 1'b0;
        end else if (!bus.enable) begin
            r_err <= 1'b0;
        end else if (w_first_end) begin
            r_err <= r_err | w_low;
        end else if (w_sym_end) begin
            if (r_bit_cnt == 3'd7) begin
                r_sym_err <= r_err | w_low;
                r_err     <= 1'b0;
            end else begin
                r_err <= r_err | w_low;
            end
        end
    end

    assign bus.sym_err = r_sym_err;
`else
    assign bus.sym_err = 1'b0;
`endif
endmodule

// File: tb/tb_msk_demodulator.sv
// Directed bench for msk_demodulator: sine-shaped MSK symbols in, decided bits/bytes checked.
module tb_msk_demodulator;
    localparam int SPB = 32;

    logic g_clk_rx = 1'b0;
    logic reset;
    msk_demodulator_if bus ();

    msk_demodulator #(.SAMPLES_PER_BIT(SPB), .ERR_THRESH(64)) dut (
        .g_clk_rx (g_clk_rx),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 g_clk_rx = ~g_clk_rx;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge g_clk_rx) cyc <= cyc + 1;

    logic       bits_q[$];
    logic [7:0] bytes_q[$];
    logic       errs_q[$];
    int         edge_q[$];
    int         n_bitv  = 0;
    int         n_bytev = 0;

    always @(negedge g_clk_rx) begin
        if (bus.bit_valid === 1'b1) begin
            bits_q.push_back(bus.bit_out);
            n_bitv++;
        end
        if (bus.byte_valid === 1'b1) begin
            bytes_q.push_back(bus.data_out);
            errs_q.push_back(bus.sym_err);
            edge_q.push_back(cyc);
            n_bytev++;
        end
    end

    int first_edge = 0;
    bit started    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        @(posedge g_clk_rx);
        #1;
        bus.sample_valid = v;
        bus.data_in      = d;
        if (v && !started) begin
            first_edge = cyc + 1;
            started    = 1'b1;
        end
    endtask

    // Bit 1: half sine cycle per symbol; bit 0: full cycle. p is the starting polarity.
    function automatic logic [7:0] samp(input logic b, input int n, input int p);
        real ang;
        int  v;
        ang = (b ? 3.14159265 : 6.2831853) * (real'(n) + 0.5) / real'(SPB);
        v   = int'(100.0 * $sin(ang));
        return 8'(128 + p * v);
    endfunction

    task automatic send_sym(input logic b, input int p, input bit gap, input bit flat);
        for (int n = 0; n < SPB; n++) begin
            if (gap) tick(1'b0, 8'h55);
            tick(1'b1, flat ? 8'd128 : samp(b, n, p));
        end
    endtask

    int phase = 1;

    // Phase-continuous byte: a half cycle flips polarity for the next symbol.
    task automatic send_byte(input logic [7:0] v, input bit gap, input int flat_idx);
        for (int i = 0; i < 8; i++) begin
            send_sym(v[i], phase, gap, i == flat_idx);
            if (v[i] && i != flat_idx) phase = -phase;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 8'd128);
    endtask

    task automatic get_byte(output logic [7:0] b, output logic e, output int ed);
        if (bytes_q.size() > 0) begin
            b  = bytes_q.pop_front();
            e  = errs_q.pop_front();
            ed = edge_q.pop_front();
        end else begin
            b  = 'x;
            e  = 'x;
            ed = -1;
        end
    endtask

    logic [7:0] b;
    logic       e;
    int         ed;
    int         bytes_before;
    logic       exp_err;
    logic [7:0] a5;

    initial begin
        reset            = 1'b1;
        bus.enable       = 1'b1;
        bus.sample_valid = 1'b1;
        bus.data_in      = 8'd200;
        repeat (2) @(posedge g_clk_rx);
        @(negedge g_clk_rx);
        chk("reset_outputs", {bus.bit_out, bus.bit_valid, bus.data_out, bus.byte_valid, bus.sym_err}, 0);

        @(posedge g_clk_rx);
        #1;
        reset      = 1'b0;
        bus.enable = 1'b0;
        for (int i = 0; i < 32; i++) tick(1'b1, 8'(i * 7));
        chk("post_reset_bit_pulses", n_bitv, 0);
        chk("post_reset_byte_pulses", n_bytev, 0);
        chk("post_reset_data_out", bus.data_out, 0);

        // Clean 0xA5 at one sample per cycle.
        tick(1'b0, 8'd128);
        bus.enable = 1'b1;
        bits_q.delete();
        started = 1'b0;
        phase   = 1;
        send_byte(8'hA5, 1'b0, -1);
        idle(3);
        chk("a5_bit_count", bits_q.size(), 8);
        chk("a5_byte_count", n_bytev, 1);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++)
            chk($sformatf("a5_bit%0d", i), (bits_q.size() > i) ? bits_q[i] : 1'bx, a5[i]);
        get_byte(b, e, ed);
        chk("a5_data", b, 8'hA5);
        chk("a5_sym_err", e, 1'b0);
        chk("a5_latency", ed - first_edge, 255);

        // Phase independence: 1 at +, 1 at -, 0 at +, 0 at -, then four more 0s.
        bits_q.delete();
        send_sym(1'b1, 1, 1'b0, 1'b0);
        send_sym(1'b1, -1, 1'b0, 1'b0);
        send_sym(1'b0, 1, 1'b0, 1'b0);
        send_sym(1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_sym(1'b0, 1, 1'b0, 1'b0);
        idle(3);
        chk("phase_bit0", (bits_q.size() > 0) ? bits_q[0] : 1'bx, 1'b1);
        chk("phase_bit1", (bits_q.size() > 1) ? bits_q[1] : 1'bx, 1'b1);
        chk("phase_bit2", (bits_q.size() > 2) ? bits_q[2] : 1'bx, 1'b0);
        chk("phase_bit3", (bits_q.size() > 3) ? bits_q[3] : 1'bx, 1'b0);
        get_byte(b, e, ed);
        chk("phase_data", b, 8'h03);

        // Gapped 0x3C: one idle cycle before every sample.
        started = 1'b0;
        phase   = 1;
        send_byte(8'h3C, 1'b1, -1);
        idle(3);
        get_byte(b, e, ed);
        chk("gap_data", b, 8'h3C);
        chk("gap_latency", ed - first_edge, 510);

        // Abort after three bits of 0xFF, then a full 0x81.
        bytes_before = n_bytev;
        bits_q.delete();
        phase = 1;
        for (int i = 0; i < 3; i++) begin
            send_sym(1'b1, phase, 1'b0, 1'b0);
            phase = -phase;
        end
        tick(1'b0, 8'd128);
        bus.enable = 1'b0;
        tick(1'b1, 8'd250);
        tick(1'b0, 8'd128);
        chk("abort_data_hold", bus.data_out, 8'h3C);
        bus.enable = 1'b1;
        phase = 1;
        send_byte(8'h81, 1'b0, -1);
        idle(3);
        chk("abort_byte_count", n_bytev - bytes_before, 1);
        chk("abort_bit_count", bits_q.size(), 11);
        get_byte(b, e, ed);
        chk("abort_data", b, 8'h81);

        // Symbol 3 of 0x00 flattened to mid-scale: zero sums decide as 1, low confidence.
`ifdef MSK_DEMOD_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        phase = 1;
        send_byte(8'h00, 1'b0, 3);
        idle(3);
        get_byte(b, e, ed);
        chk("flat_data", b, 8'h08);
        chk("flat_sym_err", e, exp_err);
        send_byte(8'h00, 1'b0, -1);
        idle(3);
        get_byte(b, e, ed);
        chk("clean00_data", b, 8'h00);
        chk("clean00_sym_err", e, 1'b0);

        // Reset mid-byte clears outputs and emits nothing.
        bytes_before = n_bytev;
        for (int i = 0; i < 3; i++) send_sym(1'b0, 1, 1'b0, 1'b0);
        tick(1'b1, 8'd128);
        reset = 1'b1;
        tick(1'b0, 8'd128);
        reset = 1'b0;
        idle(2);
        chk("midreset_data_out", bus.data_out, 0);
        chk("midreset_sym_err", bus.sym_err, 0);
        chk("midreset_byte_count", n_bytev - bytes_before, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
